pwm_multi_gen: RTL and testbench
================================

# pwm_multi_gen

Parametrised multi-channel PWM generator for the DE10-Lite ADC/display datapath. It supersedes the single 3-bit fixed-period generator with CH independent duty channels on one shared period counter. Width, period, a clock prescaler and glitch-free double-buffered duty updates are all configurable. Duty values arrive from the control logic through a simple write port and take effect only at a period boundary.

## Interface
Parameters:
- CH, 4: number of PWM channels (1..16)
- W, 8: width of the period counter and of the duty values
- PRESC_W, 8: prescaler width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run; low holds the counters at 0 and forces every output low
- period  in  W  period value P, sampled at each period boundary
- prescale  in  PRESC_W  counter advances once every prescale+1 clk cycles
- duty_wr  in  1  one-cycle write strobe for the shadow duty register
- duty_ch  in  clog2(CH) (min 1)  channel index for the write
- duty_data  in  W  duty value D
- pwm  out  CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse at the start of each period

## Operation
- Reset (reset_n=0 at an edge): cnt=0, presc_cnt=0, all shadow and active duty registers=0, latched period=0, pwm=0, period_tick=0. Reset takes priority over every other input. Reset mid-period aborts the period immediately.
- Write port: when duty_wr=1, shadow[duty_ch] <= duty_data. If duty_ch >= CH, the write is ignored. Writes are accepted in any cycle, including while enable=0.
- Prescaler: presc_cnt counts 0..prescale. A tick occurs when presc_cnt==prescale, and presc_cnt then wraps to 0. With prescale=0, every cycle is a tick.
- Edge-aligned counting: on each tick, cnt counts 0..Pl and wraps to 0, where Pl is the latched period. A period lasts (Pl+1) ticks.
- Boundary: the boundary is the tick on which cnt wraps (or the first tick after enable rises). At the boundary: Pl <= period and active[i] <= shadow[i] for all i.
- Shadow/write collision: a write in the boundary cycle lands in shadow only. active takes the pre-write shadow value, and the new value applies at the next boundary.
- Compare: pwm[i] <= enable && (cnt_next < active[i]_next). Consequences:
  - D=0 gives pwm constantly low.
  - D >= Pl+1 gives pwm constantly high.
  - Otherwise pwm is high for D ticks, then low for Pl+1-D ticks.
- Degenerate period: Pl=0 gives a 1-tick period. Any D>=1 gives pwm high.
- enable=0: cnt, presc_cnt and pwm are held at 0, and active[i] tracks shadow[i] every cycle. When enable rises, the first period starts with the current shadow values.
- Comparison is unsigned, full W bits. No arithmetic overflow is possible because cnt never exceeds Pl.

## Timing
- Output latency: pwm and period_tick are registered. If enable is sampled high at edge E, then pwm reflects cnt=0 and period_tick=1 from edge E+1. The first pwm rising edge therefore lags enable by 1 clk.
- period_tick is high for exactly one clk cycle per period, coincident with the first clk cycle of cnt=0. It is one cycle wide even when prescale>0.
- Example: prescale=0, P=9, D=3 gives a 10-cycle period, 3 high / 7 low.
- Example: prescale=1 doubles every duration.
- A duty write takes effect at the first boundary after the write edge. Latency ranges from 1 to (Pl+1)·(prescale+1) clk cycles.
- enable falling at edge E: pwm=0 and period_tick=0 from edge E+1.

## Configuration
- Macro: PWM_MULTI_GEN_CENTER_EN.
- Defined: adds input port center (1 bit), sampled at each boundary.
  - center=1 gives center-aligned counting: cnt counts up 0..Pl-1, then down Pl-1..0, so each endpoint is held for 2 ticks. The period is 2·Pl ticks.
  - pwm is high when cnt < D, giving 2·D high ticks centred on the boundary. D >= Pl gives constant high.
  - Pl=0 is treated as Pl=1.
  - The boundary and shadow transfer occur when the down-count leaves 0.
- Not defined: the center port does not exist, and only edge-aligned behaviour is built.

## Test plan
- Reset and defaults: hold reset_n=0 for 3 cycles with enable=1 -> pwm=0 and period_tick=0 throughout. After release with P=9 and all D=0 -> pwm stays 0 and period_tick pulses every 10 cycles.
- Basic duty: prescale=0, P=9, D=[0,3,9,10] on channels 0..3 -> per 10-cycle period, high counts are 0, 3, 9 and 10. The first rising edge is 1 clk after enable is sampled high.
- Double buffering: write ch1 D=7 mid-period (cnt=4) while running with D=3 -> the current period keeps 3 high cycles and the next period has 7. A second write issued in the exact boundary cycle appears one period later still.
- Prescaler and period change: prescale=2, P=4, D=2 -> 15-cycle period with 6 high. Changing period to 1 mid-period takes effect only after the current 15-cycle period completes.
- Invalid index and enable toggle: duty_wr with duty_ch=CH -> no channel changes. Dropping enable mid-period -> pwm=0 next cycle, and re-enabling restarts at cnt=0 with a fresh period_tick.
- Center mode (macro defined): center=1, P=8, D=3, prescale=0 -> 16-cycle period with 6 high cycles spanning the boundary (3 before, 3 after); D=8 gives constant high.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: CH-channel PWM generator driven by one shared period counter.
// A prescaler slows the counter, and duty values are double-buffered: writes go
// to shadow registers, and the shadow values move to the active registers only
// at a period boundary. The period is latched at the same boundary.
// Optional build macro PWM_MULTI_GEN_CENTER_EN adds the 'center' input, which
// selects center-aligned (up/down) counting at each boundary.
module pwm_multi_gen #(
    parameter int CH      = 4,
    parameter int W       = 8,
    parameter int PRESC_W = 8,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [W-1:0]       period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               duty_wr,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [W-1:0]       duty_data,
`ifdef PWM_MULTI_GEN_CENTER_EN
    input  logic               center,
`endif
    output logic [CH-1:0]      pwm,
    output logic               period_tick
);

    logic [W-1:0]       cnt_reg, cnt_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [W-1:0]       pl_reg, pl_next;
    logic               started_reg;
    logic               tick;
    logic               boundary;
    logic [W-1:0]       shadow_reg  [CH];
    logic [W-1:0]       active_reg  [CH];
    logic [W-1:0]       active_next [CH];
    logic [CH-1:0]      pwm_next;

`ifdef PWM_MULTI_GEN_CENTER_EN
    logic               center_reg, center_next;
    logic               dir_reg, dir_next;   // 0 = counting up, 1 = counting down
    logic [W-1:0]       pl_eff;

    // A latched period of 0 behaves as 1 in center mode.
    assign pl_eff = (pl_reg == '0) ? {{(W-1){1'b0}}, 1'b1} : pl_reg;
`endif

    // Prescaler, period counter and boundary detection.
    always_comb begin
        cnt_next   = cnt_reg;
        presc_next = presc_reg;
        pl_next    = pl_reg;
        tick       = 1'b0;
        boundary   = 1'b0;
`ifdef PWM_MULTI_GEN_CENTER_EN
        center_next = center_reg;
        dir_next    = dir_reg;
`endif
        if (!enable) begin
            cnt_next   = '0;
            presc_next = '0;
`ifdef PWM_MULTI_GEN_CENTER_EN
            dir_next   = 1'b0;
`endif
        end else if (!started_reg) begin
            // First edge with enable high opens a fresh period.
            boundary = 1'b1;
        end else begin
            // '>=' also recovers cleanly if prescale is lowered mid-count.
            tick       = (presc_reg >= prescale);
            presc_next = tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
`ifdef PWM_MULTI_GEN_CENTER_EN
                if (center_reg) begin
                    if (!dir_reg) begin
                        // The top value is held for a second tick while turning round.
                        if (cnt_reg >= pl_eff - 1'b1) dir_next = 1'b1;
                        else                          cnt_next = cnt_reg + 1'b1;
                    end else if (cnt_reg == '0) begin
                        boundary = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end else if (cnt_reg >= pl_reg) begin
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`else
                if (cnt_reg >= pl_reg) boundary = 1'b1;
                else                   cnt_next = cnt_reg + 1'b1;
`endif
            end
        end
        if (boundary) begin
            cnt_next   = '0;
            presc_next = '0;
            pl_next    = period;
`ifdef PWM_MULTI_GEN_CENTER_EN
            center_next = center;
            dir_next    = 1'b0;
`endif
        end
    end

    // Per-channel duty transfer and compare against the next counter value.
    // The compare uses next-state values so that pwm is aligned with cnt.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            assign active_next[gi] = (!enable || boundary) ? shadow_reg[gi] : active_reg[gi];
            assign pwm_next[gi]    = enable && (cnt_next < active_next[gi]);
        end
    endgenerate

    // State registers, shadow write port and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            presc_reg   <= '0;
            pl_reg      <= '0;
            started_reg <= 1'b0;
            pwm         <= '0;
            period_tick <= 1'b0;
`ifdef PWM_MULTI_GEN_CENTER_EN
            center_reg  <= 1'b0;
            dir_reg     <= 1'b0;
`endif
            for (int i = 0; i < CH; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            cnt_reg     <= cnt_next;
            presc_reg   <= presc_next;
            pl_reg      <= pl_next;
            started_reg <= enable;
            pwm         <= pwm_next;
            period_tick <= boundary;
`ifdef PWM_MULTI_GEN_CENTER_EN
            center_reg  <= center_next;
            dir_reg     <= dir_next;
`endif
            for (int i = 0; i < CH; i++) begin
                active_reg[i] <= active_next[i];
                // Out-of-range indices match no channel and are dropped.
                if (duty_wr && (duty_ch == CH_W'(i))) shadow_reg[i] <= duty_data;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: self-checking bench for pwm_multi_gen (edge-aligned build).
// Uses CH=5 so that a 3-bit channel index can address a non-existent channel.
module tb_pwm_multi_gen;

    localparam int CH      = 5;
    localparam int W       = 8;
    localparam int PRESC_W = 8;
    localparam int CH_W    = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [W-1:0]       period;
    logic [PRESC_W-1:0] prescale;
    logic               duty_wr;
    logic [CH_W-1:0]    duty_ch;
    logic [W-1:0]       duty_data;
    logic [CH-1:0]      pwm;
    logic               period_tick;

    always #5 clk = ~clk;

    pwm_multi_gen #(.CH(CH), .W(W), .PRESC_W(PRESC_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .period      (period),
        .prescale    (prescale),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
        .pwm         (pwm),
        .period_tick (period_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the clk-cycle position inside the current period.
    // The period lasts (Pl+1)*(prescale+1) cycles, and the counter value is pos/(prescale+1).
    int unsigned   m_pos;
    bit            m_run;
    int unsigned   m_pl;
    int unsigned   m_sh  [CH];
    int unsigned   m_act [CH];
    logic [CH-1:0] exp_pwm  = '0;
    logic          exp_tick = 1'b0;

    // Advance the model on every rising edge, using the inputs driven on the previous falling edge.
    always @(posedge clk) begin
        int unsigned ps;
        int unsigned len;
        ps = int'(prescale) + 1;
        if (!reset_n) begin
            m_run = 0; m_pos = 0; m_pl = 0;
            for (int i = 0; i < CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            exp_pwm = '0; exp_tick = 1'b0;
        end else begin
            if (!enable) begin
                m_run = 0;
                for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
                exp_pwm = '0; exp_tick = 1'b0;
            end else begin
                len = (m_pl + 1) * ps;
                if (!m_run || (m_pos + 1 >= len)) begin
                    m_run = 1; m_pos = 0; m_pl = int'(period);
                    for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
                end else begin
                    m_pos++;
                end
                exp_tick = (m_pos == 0);
                for (int i = 0; i < CH; i++) exp_pwm[i] = ((m_pos / ps) < m_act[i]);
            end
            if (duty_wr && (int'(duty_ch) < CH)) m_sh[duty_ch] = int'(duty_data);
        end
    end

    // Compare DUT outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pwm", int'(pwm), int'(exp_pwm));
            check("model_tick", int'(period_tick), int'(exp_tick));
        end
    end

    int acc [CH];
    int acc_len;

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic clr_acc();
        for (int i = 0; i < CH; i++) acc[i] = 0;
        acc_len = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            for (int i = 0; i < CH; i++) acc[i] += int'(pwm[i]);
            acc_len++;
            cyc(1);
        end
    endtask

    // Accumulate cycles until the next period_tick (the current cycle is always counted).
    task automatic run_to_tick();
        int guard;
        guard = 0;
        do begin
            for (int i = 0; i < CH; i++) acc[i] += int'(pwm[i]);
            acc_len++;
            cyc(1);
            guard++;
        end while (!period_tick && guard < 5000);
        if (guard >= 5000) check("period_tick_timeout", 0, 1);
    endtask

    task automatic write_duty(input int ch, input int d);
        duty_wr   = 1'b1;
        duty_ch   = CH_W'(ch);
        duty_data = W'(d);
        cyc(1);
        duty_wr   = 1'b0;
    endtask

    typedef struct {
        int per;
        int presc;
        int duty;
        int exp_len;
        int exp_high;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];
    int   exp_multi [CH];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{9,   0, 0,   10,  0};
        vecs[1]  = '{9,   0, 3,   10,  3};
        vecs[2]  = '{9,   0, 9,   10,  9};
        vecs[3]  = '{9,   0, 10,  10,  10};
        vecs[4]  = '{9,   0, 200, 10,  10};
        vecs[5]  = '{4,   2, 2,   15,  6};
        vecs[6]  = '{0,   0, 1,   1,   1};
        vecs[7]  = '{0,   0, 0,   1,   0};
        vecs[8]  = '{1,   1, 1,   4,   2};
        vecs[9]  = '{255, 0, 128, 256, 128};
        vecs[10] = '{3,   3, 4,   16,  16};
        exp_multi = '{0, 3, 9, 10, 5};

        reset_n = 1'b0; enable = 1'b1; period = 8'd9; prescale = '0;
        duty_wr = 1'b0; duty_ch = '0; duty_data = '0;

        // Reset held with enable high: outputs stay low.
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk_en = 1'b1;
            check("rst_pwm", int'(pwm), 0);
            check("rst_tick", int'(period_tick), 0);
        end
        reset_n = 1'b1;
        cyc(1);
        check("rst_first_tick", int'(period_tick), 1);
        for (int p = 0; p < 2; p++) begin
            clr_acc(); run_to_tick();
            check("rst_period_len", acc_len, 10);
            for (int i = 0; i < CH; i++) check("rst_high", acc[i], 0);
        end

        // Table of single-channel period/duty/prescale vectors.
        for (int v = 0; v < NV; v++) begin
            enable = 1'b0; period = W'(vecs[v].per); prescale = PRESC_W'(vecs[v].presc);
            write_duty(0, vecs[v].duty);
            check("tbl_idle_pwm", int'(pwm), 0);
            enable = 1'b1;
            cyc(1);
            check("tbl_first_tick", int'(period_tick), 1);
            check("tbl_first_pwm", int'(pwm[0]), int'(vecs[v].duty != 0));
            clr_acc(); run_to_tick();
            check("tbl_len", acc_len, vecs[v].exp_len);
            check("tbl_high", acc[0], vecs[v].exp_high);
        end

        // All channels at once, with writes to indices that do not exist.
        enable = 1'b0; period = 8'd9; prescale = '0;
        for (int i = 0; i < CH; i++) write_duty(i, exp_multi[i]);
        write_duty(5, 8'hAA);
        write_duty(7, 8'h55);
        check("multi_idle_pwm", int'(pwm), 0);
        enable = 1'b1;
        cyc(1);
        check("multi_first_tick", int'(period_tick), 1);
        check("multi_first_pwm", int'(pwm), int'(5'b11110));
        clr_acc(); run_to_tick();
        check("multi_len", acc_len, 10);
        for (int i = 0; i < CH; i++) check("multi_high", acc[i], exp_multi[i]);

        // Enable dropped mid-period, then restored.
        run(4);
        enable = 1'b0;
        cyc(1);
        check("dis_pwm", int'(pwm), 0);
        check("dis_tick", int'(period_tick), 0);
        cyc(2);
        check("dis_hold_pwm", int'(pwm), 0);
        enable = 1'b1;
        cyc(1);
        check("reen_tick", int'(period_tick), 1);
        check("reen_pwm", int'(pwm), int'(5'b11110));
        clr_acc(); run_to_tick();
        check("reen_len", acc_len, 10);
        check("reen_high1", acc[1], 3);

        // Double buffering: a mid-period write and a boundary-cycle write.
        clr_acc(); run(4);
        duty_wr = 1'b1; duty_ch = 3'd1; duty_data = 8'd7;
        run(1);
        duty_wr = 1'b0;
        run_to_tick();
        check("db_cur_len", acc_len, 10);
        check("db_cur_high", acc[1], 3);
        clr_acc(); run(9);
        duty_wr = 1'b1; duty_ch = 3'd1; duty_data = 8'd2;
        run(1);
        duty_wr = 1'b0;
        check("db_boundary_tick", int'(period_tick), 1);
        check("db_next_high", acc[1], 7);
        clr_acc(); run_to_tick();
        check("db_collision_high", acc[1], 7);
        clr_acc(); run_to_tick();
        check("db_late_high", acc[1], 2);

        // Prescaler, plus a period change that waits for the boundary.
        enable = 1'b0; prescale = 8'd2; period = 8'd4;
        write_duty(0, 2);
        enable = 1'b1;
        cyc(1);
        clr_acc(); run(5);
        period = 8'd1;
        run_to_tick();
        check("presc_len", acc_len, 15);
        check("presc_high", acc[0], 6);
        clr_acc(); run_to_tick();
        check("newper_len", acc_len, 6);
        check("newper_high", acc[0], 6);

        // Reset in the middle of a period.
        run(3);
        reset_n = 1'b0;
        cyc(1);
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_tick", int'(period_tick), 0);
        reset_n = 1'b1;
        cyc(1);
        check("midrst_restart_tick", int'(period_tick), 1);
        check("midrst_restart_pwm", int'(pwm), 0);
        clr_acc(); run_to_tick();
        check("midrst_len", acc_len, 6);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int s = 0; s < 40; s++) begin
            enable   = 1'b0;
            prescale = PRESC_W'($urandom_range(0, 3));
            period   = W'($urandom_range(0, 12));
            repeat ($urandom_range(1, 4)) write_duty(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            enable = 1'b1;
            repeat ($urandom_range(20, 120)) begin
                duty_wr   = ($urandom_range(0, 3) == 0);
                duty_ch   = CH_W'($urandom_range(0, 7));
                duty_data = W'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) period = W'($urandom_range(0, 12));
                enable  = ($urandom_range(0, 29) != 0);
                reset_n = ($urandom_range(0, 99) != 0);
                cyc(1);
            end
            duty_wr = 1'b0;
            reset_n = 1'b1;
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
